// File: rtl/sim_mem_io.sv
// Data memory and simulation I/O unit on the CPU data bus.
// Provides a 1-cycle synchronous-read RAM, a buffered output channel drained over
// valid/ready, a sticky halt register with exit code, and a cycle-timeout watchdog.
// OUT_ADDR and HALT_ADDR must differ and fit in ADDR_WIDTH bits.
// FIFO_DEPTH must be a power of two (>= 2), and TIMEOUT must be >= 1.
module sim_mem_io #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR   = ADDR_WIDTH'(1),
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = ADDR_WIDTH'(2),
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic                  timed_out,
  output logic [31:0]           cycle_count
);

  localparam int unsigned     RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned     PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]     TIMEOUT_M1 = 32'(TIMEOUT - 1);

  logic [DATA_WIDTH-1:0] ram      [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic                  running_c;
  logic                  wr_en_c;
  logic                  push_req_c;
  logic                  push_ok_c;
  logic                  pop_c;
  logic                  halt_wr_c;
  logic                  expire_c;
  logic [PTR_W-1:0]      rd_ptr_nxt_c;
  logic [PTR_W-1:0]      wr_ptr_nxt_c;
  logic [CNT_W-1:0]      fifo_cnt_nxt_c;
  logic [DATA_WIDTH-1:0] head_nxt_c;

  // Bus decode, FIFO bookkeeping and next head value.
  always_comb begin
    running_c  = !halted && !timed_out;
    wr_en_c    = rst && mem_wr && running_c;
    push_req_c = wr_en_c && (mem_addr == OUT_ADDR);
    halt_wr_c  = wr_en_c && (mem_addr == HALT_ADDR);
    pop_c      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok_c  = push_req_c && ((fifo_cnt != FIFO_FULL) || pop_c);
    // Halt wins over a watchdog expiry landing in the same cycle.
    expire_c   = running_c && !halt_wr_c && (cycle_count >= TIMEOUT_M1);

    rd_ptr_nxt_c   = rd_ptr;
    wr_ptr_nxt_c   = wr_ptr;
    fifo_cnt_nxt_c = fifo_cnt;
    if (pop_c) begin
      rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
    end
    if (push_ok_c) begin
      wr_ptr_nxt_c = wr_ptr + PTR_W'(1);
    end
    if (push_ok_c && !pop_c) begin
      fifo_cnt_nxt_c = fifo_cnt + CNT_W'(1);
    end else if (!push_ok_c && pop_c) begin
      fifo_cnt_nxt_c = fifo_cnt - CNT_W'(1);
    end

    // Forward the incoming word when it lands in the slot that becomes the head.
    head_nxt_c = '0;
    if (fifo_cnt_nxt_c != '0) begin
      if (push_ok_c && (wr_ptr == rd_ptr_nxt_c)) begin
        head_nxt_c = wr_data;
      end else begin
        head_nxt_c = fifo_mem[rd_ptr_nxt_c];
      end
    end
  end

  // RAM and FIFO storage arrays; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      ram[mem_addr] <= wr_data;
    end
    if (push_ok_c) begin
      fifo_mem[wr_ptr] <= wr_data;
    end
  end

  // Registered read port; old data on read-during-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= ram[mem_addr];
    end
  end

  // Output FIFO pointers, occupancy, registered head and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt_c;
      wr_ptr    <= wr_ptr_nxt_c;
      fifo_cnt  <= fifo_cnt_nxt_c;
      out_valid <= (fifo_cnt_nxt_c != '0);
      out_data  <= head_nxt_c;
      if (push_req_c && !push_ok_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Halt register, watchdog and saturating cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted      <= 1'b0;
      exit_code   <= '0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (halt_wr_c) begin
        halted    <= 1'b1;
        exit_code <= wr_data;
      end
      if (expire_c) begin
        timed_out <= 1'b1;
      end
      if (cycle_count != 32'hFFFF_FFFF) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sim_mem_io.sv
// Scoreboard bench for sim_mem_io: directed scenarios plus randomized epochs,
// checked against a behavioural model of the memory, output queue, halt and watchdog.
module tb_sim_mem_io;

  localparam int unsigned FD     = 4;
  localparam int unsigned TO     = 20;
  localparam logic [7:0]  OUT_A  = 8'h01;
  localparam logic [7:0]  HALT_A = 8'h02;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        overflow;
  logic        halted;
  logic [7:0]  exit_code;
  logic        timed_out;
  logic [31:0] cycle_count;

  sim_mem_io #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .OUT_ADDR  (OUT_A),
    .HALT_ADDR (HALT_A),
    .FIFO_DEPTH(FD),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .halted     (halted),
    .exit_code  (exit_code),
    .timed_out  (timed_out),
    .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] m_ram   [256];
  bit         m_known [256];
  logic [7:0] exp_q   [$];
  int         m_cnt;
  bit         m_ovf;
  bit         m_halted;
  bit         m_to;
  logic [7:0] m_exit;
  longint     m_cyc;
  logic [7:0] exp_rd;
  bit         exp_rd_known;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit run;
    bit pop;
    bit acc;
    bit hwr;
    run = !m_halted && !m_to;
    pop = (m_cnt > 0) && out_ready;
    acc = 1'b0;
    hwr = 1'b0;
    exp_rd       = m_ram[mem_addr];
    exp_rd_known = m_known[mem_addr];
    if (mem_wr && run) begin
      m_ram[mem_addr]   = wr_data;
      m_known[mem_addr] = 1'b1;
      if (mem_addr == OUT_A) begin
        if (m_cnt < int'(FD) || pop) begin
          exp_q.push_back(wr_data);
          acc = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (mem_addr == HALT_A) begin
        hwr      = 1'b1;
        m_halted = 1'b1;
        m_exit   = wr_data;
      end
    end
    m_cnt = m_cnt - int'(pop) + int'(acc);
    if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
    if (run && !hwr && m_cyc >= longint'(TO)) m_to = 1'b1;
  endtask

  // Compare the non-stream outputs after an edge.
  task automatic post_checks();
    if (exp_rd_known) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    chk("out_valid",   32'(out_valid),   32'(m_cnt > 0));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("halted",      32'(halted),      32'(m_halted));
    chk("exit_code",   32'(exit_code),   32'(m_exit));
    chk("timed_out",   32'(timed_out),   32'(m_to));
    chk("cycle_count", cycle_count,      32'(m_cyc));
  endtask

  // One bus cycle; called and returns at posedge+2.
  task automatic cycle(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit rdy);
    mem_wr    = wr;
    mem_addr  = a;
    wr_data   = d;
    out_ready = rdy;
    model_step();
    @(posedge clk);
    #2;
    post_checks();
  endtask

  // Asynchronous reset mid-period; outputs must clear before any edge.
  task automatic do_reset();
    rst       = 1'b0;
    mem_wr    = 1'b0;
    out_ready = 1'b0;
    wr_data   = 8'h00;
    #1;
    chk("rst_rd_data",     32'(rd_data),   32'h0);
    chk("rst_out_valid",   32'(out_valid), 32'h0);
    chk("rst_out_data",    32'(out_data),  32'h0);
    chk("rst_overflow",    32'(overflow),  32'h0);
    chk("rst_halted",      32'(halted),    32'h0);
    chk("rst_exit_code",   32'(exit_code), 32'h0);
    chk("rst_timed_out",   32'(timed_out), 32'h0);
    chk("rst_cycle_count", cycle_count,    32'h0);
    exp_q.delete();
    m_cnt    = 0;
    m_ovf    = 1'b0;
    m_halted = 1'b0;
    m_to     = 1'b0;
    m_exit   = 8'h00;
    m_cyc    = 0;
    @(negedge clk);
    rst = 1'b1;
    model_step();
    @(posedge clk);
    #2;
    post_checks();
  endtask

  // Stream monitor: every accepted output word must match the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_pop: got 0x%0h, expected no entry (t=%0t)", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    rst       = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 8'h00;
    wr_data   = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    #2;

    // RAM readback
    do_reset();
    cycle(1'b1, 8'h10, 8'h5A, 1'b0);
    cycle(1'b0, 8'h10, 8'h00, 1'b0);
    chk("tp1_readback", 32'(rd_data), 32'h5A);

    // Output drain in order
    cycle(1'b1, OUT_A, 8'h11, 1'b0);
    cycle(1'b1, OUT_A, 8'h22, 1'b0);
    cycle(1'b1, OUT_A, 8'h33, 1'b0);
    chk("tp2_head_held", 32'(out_data), 32'h11);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("tp2_drained", 32'(out_valid), 32'h0);

    // Overflow, then push+pop while full
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, OUT_A, 8'(8'h40 + i), 1'b0);
    chk("tp3_overflow", 32'(overflow), 32'h1);
    cycle(1'b1, OUT_A, 8'h99, 1'b1);
    chk("tp3_full_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Halt blocks later writes and pushes
    do_reset();
    cycle(1'b1, HALT_A, 8'h2A, 1'b0);
    chk("tp4_exit_code", 32'(exit_code), 32'h2A);
    cycle(1'b1, 8'h10, 8'hFF, 1'b0);
    cycle(1'b1, HALT_A, 8'h77, 1'b0);
    cycle(1'b0, 8'h10, 8'h00, 1'b0);
    chk("tp4_ram_kept", 32'(rd_data), 32'h5A);
    cycle(1'b1, OUT_A, 8'h66, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("tp4_no_push", 32'(out_valid), 32'h0);

    // Watchdog expiry with no writes
    do_reset();
    for (int i = 0; i < 22; i++) cycle(1'b0, 8'h10, 8'h00, 1'b0);
    chk("tp5_timed_out", 32'(timed_out), 32'h1);
    cycle(1'b1, 8'h10, 8'hEE, 1'b0);
    cycle(1'b0, 8'h10, 8'h00, 1'b0);

    // Halt write on the expiry edge wins
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, HALT_A, 8'h3C, 1'b0);
    chk("tp5_halt_wins", 32'({halted, timed_out}), 32'h2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);

    // Async reset with queued entries while halted, then normal use
    do_reset();
    cycle(1'b1, OUT_A, 8'hA1, 1'b0);
    cycle(1'b1, OUT_A, 8'hB2, 1'b0);
    cycle(1'b1, HALT_A, 8'h55, 1'b0);
    do_reset();
    cycle(1'b1, OUT_A, 8'hC3, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1, 8'h20, 8'h6E, 1'b0);
    cycle(1'b0, 8'h20, 8'h00, 1'b0);
    chk("tp6_after_reset", 32'(rd_data), 32'h6E);

    // Randomized epochs
    for (int e = 0; e < 20; e++) begin
      do_reset();
      for (int c = 0; c < 28; c++) begin
        int unsigned r;
        logic [7:0]  a;
        r = $urandom_range(0, 99);
        if (r < 35)      a = OUT_A;
        else if (r < 40) a = HALT_A;
        else             a = 8'($urandom_range(0, 31));
        cycle($urandom_range(0, 3) != 0, a, 8'($urandom_range(0, 255)),
              $urandom_range(0, 2) == 0);
      end
      for (int c = 0; c < 5; c++) cycle(1'b0, 8'($urandom_range(0, 31)), 8'h00, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
